// File: rtl/mac_pkg.sv
// Shared MAC-side constants and the TX arbiter state encoding.
package mac_pkg;

  localparam int ETH_MIN_FRAME   = 64;
  localparam int ETH_MAX_FRAME   = 1518;
  localparam int ETH_FCS_BYTES   = 4;
  localparam int ETH_DEFAULT_IFG = 12;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DRAIN,
    IFG
  } arb_state_t;

endpackage

// File: rtl/mac_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; first request at or above ptr, modulo N.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic [W-1:0] j;
  logic         hit;

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise paths that skip an assignment infer latches.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = W'((int'(ptr) + i) % N);
      if (!hit && req[j]) begin
        hit    = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arb.sv
// Frame-granular round-robin arbiter feeding one MAC TX byte stream from N_SRC sources.
// Optional MAC_TX_ARB_STRICT_PRIO_EN: source 0 always wins arbitration when requesting.
module mac_tx_arb
  import mac_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int MAX_BYTES  = ETH_MAX_FRAME - ETH_FCS_BYTES,
  parameter int IFG_CYCLES = ETH_DEFAULT_IFG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         src_valid,
  output logic [N_SRC-1:0]         src_ready,
  input  logic [8*N_SRC-1:0]       src_data,
  input  logic [N_SRC-1:0]         src_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     busy,
  output logic                     trunc_pulse,
  output logic [15:0]              frames_sent
);

  localparam int GW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IW-1:0] IFG_LOAD = IW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam arb_state_t GAP_STATE = (IFG_CYCLES == 0) ? IDLE : IFG;

  arb_state_t     state, state_nxt;
  logic [GW-1:0]  grant_id_nxt, rr_ptr, rr_ptr_nxt, grant_inc, pick_idx;
  logic [CW-1:0]  byte_cnt, byte_cnt_nxt;
  logic [IW-1:0]  ifg_cnt, ifg_cnt_nxt;
  logic [15:0]    frames_sent_nxt;
  logic           trunc_nxt;
  logic [N_SRC-1:0] pick_req, pick_gnt;
  logic           g_valid, g_last, force_last, xfer;

`ifdef MAC_TX_ARB_STRICT_PRIO_EN
  // Source 0 is handled outside the rotation, so it never competes in the picker.
  assign pick_req = {src_valid[N_SRC-1:1], 1'b0};
`else
  assign pick_req = src_valid;
`endif

  rr_pick #(.N(N_SRC)) u_pick (
    .req (pick_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign g_valid    = src_valid[grant_id];
  assign g_last     = src_last[grant_id];
  assign force_last = (byte_cnt == CW'(MAX_BYTES - 1));
  assign xfer       = out_valid && out_ready;
  assign grant_inc  = (grant_id == GW'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
  assign busy       = (state != IDLE);

  always_comb begin
    src_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      PASS: begin
        src_ready[grant_id] = out_ready;
        out_valid           = g_valid;
        out_data            = src_data[{grant_id, 3'b000} +: 8];
        out_last            = g_last | force_last;
      end
      DRAIN:   src_ready[grant_id] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    grant_id_nxt    = grant_id;
    rr_ptr_nxt      = rr_ptr;
    byte_cnt_nxt    = byte_cnt;
    ifg_cnt_nxt     = ifg_cnt;
    frames_sent_nxt = frames_sent;
    trunc_nxt       = 1'b0;
    case (state)
      IDLE: begin
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
        if (src_valid[0]) begin
          grant_id_nxt = '0;
          state_nxt    = PASS;
        end else if (|pick_gnt) begin
          grant_id_nxt = pick_idx;
          state_nxt    = PASS;
        end
`else
        if (|pick_gnt) begin
          grant_id_nxt = pick_idx;
          state_nxt    = PASS;
        end
`endif
      end
      PASS: begin
        if (xfer) begin
          byte_cnt_nxt = byte_cnt + 1'b1;
          // A natural last wins over truncation when both land on the same byte.
          if (g_last || force_last) begin
            byte_cnt_nxt    = '0;
            frames_sent_nxt = frames_sent + 16'd1;
            trunc_nxt       = !g_last;
            ifg_cnt_nxt     = IFG_LOAD;
            state_nxt       = g_last ? GAP_STATE : DRAIN;
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
            if (grant_id != '0) rr_ptr_nxt = grant_inc;
`else
            rr_ptr_nxt = grant_inc;
`endif
          end
        end
      end
      DRAIN: begin
        if (g_valid && g_last) begin
          ifg_cnt_nxt = IFG_LOAD;
          state_nxt   = GAP_STATE;
        end
      end
      IFG: begin
        if (ifg_cnt == '0) state_nxt   = IDLE;
        else               ifg_cnt_nxt = ifg_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      byte_cnt    <= '0;
      ifg_cnt     <= '0;
      frames_sent <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_id_nxt;
      rr_ptr      <= rr_ptr_nxt;
      byte_cnt    <= byte_cnt_nxt;
      ifg_cnt     <= ifg_cnt_nxt;
      frames_sent <= frames_sent_nxt;
      trunc_pulse <= trunc_nxt;
    end
  end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Directed self-checking bench for mac_tx_arb with behavioural byte sources.
module tb_mac_tx_arb;

  localparam int N   = 4;
  localparam int MAX = 1514;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] src_valid, src_ready, src_last;
  logic [8*N-1:0] src_data;
  logic         out_valid, out_ready, out_last, busy, trunc_pulse;
  logic [7:0]   out_data;
  logic [1:0]   grant_id;
  logic [15:0]  frames_sent;

  mac_tx_arb #(.N_SRC(N), .MAX_BYTES(MAX), .IFG_CYCLES(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_last(src_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .grant_id(grant_id), .busy(busy), .trunc_pulse(trunc_pulse), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int len [N];
  int pos [N];
  int nfr [N];
  int order[$];
  int gaps[$];
  int idle_run, out_cnt, last_len, drained, n_trunc;
  int data_err, ready_err, route_err, stall_err;
  logic stalled;
  logic [7:0] stall_data;
  bit toggle_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int order_at(input int k);
    return (order.size() > k) ? order[k] : -1;
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (nfr[i] > 0) p = 1'b1;
    return p;
  endfunction

  // Source i emits byte {i, pos[5:0]} so the output identifies origin and order.
  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      src_valid[i]       = (nfr[i] > 0);
      src_data[8*i +: 8] = {2'(i), 6'(pos[i])};
      src_last[i]        = (nfr[i] > 0) && (pos[i] == len[i] - 1);
    end
  endtask

  task automatic clear_stats();
    order.delete();
    gaps.delete();
    idle_run = 0; last_len = 0; drained = 0; n_trunc = 0;
    data_err = 0; ready_err = 0; route_err = 0; stall_err = 0;
  endtask

  task automatic cycle();
    logic       fire_o, exp_last;
    logic [N-1:0] fs;
    int         s;
    @(negedge clk);
    fire_o   = out_valid && out_ready;
    fs       = src_valid & src_ready;
    exp_last = 1'b0;
    s        = -1;
    if (!$onehot0(src_ready)) ready_err++;
    if (stalled && out_valid && (out_data !== stall_data)) stall_err++;
    stalled    = out_valid && !out_ready;
    stall_data = out_data;
    if (fire_o) begin
      for (int i = 0; i < N; i++) if (fs[i]) s = i;
      if (!$onehot(fs)) route_err++;
      else begin
        exp_last = (pos[s] == len[s] - 1) || (out_cnt == MAX - 1);
        if (out_data !== {2'(s), 6'(pos[s])} || out_last !== exp_last) data_err++;
      end
      if (out_cnt == 0) begin
        order.push_back(s);
        gaps.push_back(idle_run);
      end
      idle_run = 0;
      if (exp_last) begin
        last_len = out_cnt + 1;
        out_cnt  = 0;
      end else out_cnt++;
    end else idle_run++;
    if (|fs && !fire_o) drained++;
    if (trunc_pulse) n_trunc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fs[i]) begin
        pos[i]++;
        if (pos[i] == len[i]) begin
          pos[i] = 0;
          nfr[i]--;
        end
      end
    end
    if (toggle_ready) out_ready = !out_ready;
    drive_src();
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while ((busy || pending()) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      len[i] = 1; pos[i] = 0; nfr[i] = 0;
    end
    out_cnt = 0; stalled = 1'b0; stall_data = '0; toggle_ready = 1'b0;
    clear_stats();
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive_src();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_src_ready",   32'(src_ready),   32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_grant_id",    32'(grant_id),    32'd0);
    check("rst_frames_sent", 32'(frames_sent), 32'd0);
    check("rst_trunc_pulse", 32'(trunc_pulse), 32'd0);
    rst_n = 1'b1;

    // All four sources, 3-byte frames, simultaneously.
    for (int i = 0; i < N; i++) begin
      len[i] = 3; nfr[i] = 1;
    end
    drive_src();
    clear_stats();
    run("rr4_done", 300);
    check("rr4_count",   32'(order.size()), 32'd4);
    check("rr4_grant0",  order_at(0), 32'd0);
    check("rr4_grant1",  order_at(1), 32'd1);
    check("rr4_grant2",  order_at(2), 32'd2);
    check("rr4_grant3",  order_at(3), 32'd3);
    check("rr4_frames",  32'(frames_sent), 32'd4);
    check("rr4_latency", (gaps.size() > 0) ? gaps[0] : -1, 32'd1);
    check("rr4_gap1",    (gaps.size() > 1) ? gaps[1] : -1, 32'd13);
    check("rr4_gap3",    (gaps.size() > 3) ? gaps[3] : -1, 32'd13);
    check("rr4_data",    data_err,  32'd0);
    check("rr4_ready",   ready_err + route_err, 32'd0);
    check("rr4_trunc",   n_trunc,   32'd0);

    // Source 2 overruns MAX by 6 bytes.
    clear_stats();
    len[2] = 1520; nfr[2] = 1;
    drive_src();
    run("trunc6_done", 2000);
    check("trunc6_len",     last_len, 32'd1514);
    check("trunc6_pulses",  n_trunc,  32'd1);
    check("trunc6_drained", drained,  32'd6);
    check("trunc6_frames",  32'(frames_sent), 32'd5);
    check("trunc6_data",    data_err + route_err, 32'd0);
    clear_stats();
    len[0] = 3; len[3] = 3; nfr[0] = 1; nfr[3] = 1;
    drive_src();
    run("post_trunc_done", 200);
    check("post_trunc_first", order_at(0), 32'd3);
    check("post_trunc_next",  order_at(1), 32'd0);

    // Exactly MAX bytes, then MAX+1 bytes, from source 1.
    clear_stats();
    len[1] = 1514; nfr[1] = 1;
    drive_src();
    run("exact_done", 2000);
    check("exact_trunc",   n_trunc,  32'd0);
    check("exact_len",     last_len, 32'd1514);
    check("exact_drained", drained,  32'd0);
    clear_stats();
    len[1] = 1515; nfr[1] = 1;
    drive_src();
    run("over1_done", 2000);
    check("over1_trunc",   n_trunc,  32'd1);
    check("over1_drained", drained,  32'd1);
    check("over1_len",     last_len, 32'd1514);
    check("over1_frames",  32'(frames_sent), 32'd9);

    // 64-byte frame with out_ready toggling every cycle.
    clear_stats();
    toggle_ready = 1'b1;
    len[0] = 64; nfr[0] = 1;
    drive_src();
    run("stall_done", 400);
    toggle_ready = 1'b0;
    out_ready = 1'b1;
    check("stall_data",   data_err + route_err, 32'd0);
    check("stall_stable", stall_err, 32'd0);
    check("stall_len",    last_len, 32'd64);
    check("stall_frames", 32'(order.size()), 32'd1);

    // Reset in the middle of a frame from source 1, after 20 bytes.
    clear_stats();
    len[1] = 40; nfr[1] = 1;
    drive_src();
    for (int n = 0; n < 200 && out_cnt < 20; n++) cycle();
    check("midrst_bytes", out_cnt, 32'd20);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      nfr[i] = 0; pos[i] = 0;
    end
    drive_src();
    out_cnt = 0;
    stalled = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_busy",      32'(busy),        32'd0);
    check("midrst_valid",     32'(out_valid),   32'd0);
    check("midrst_last",      32'(out_last),    32'd0);
    check("midrst_ready",     32'(src_ready),   32'd0);
    check("midrst_grant",     32'(grant_id),    32'd0);
    check("midrst_frames",    32'(frames_sent), 32'd0);
    check("midrst_trunc",     32'(trunc_pulse), 32'd0);
    clear_stats();
    len[0] = 3; len[3] = 3; nfr[0] = 1; nfr[3] = 1;
    drive_src();
    run("postrst_done", 200);
    check("postrst_first",  order_at(0), 32'd0);
    check("postrst_second", order_at(1), 32'd3);
    check("postrst_frames", 32'(frames_sent), 32'd2);

    // Sources 0 and 3 requesting continuously, four 2-byte frames each.
    clear_stats();
    len[0] = 2; len[3] = 2; nfr[0] = 4; nfr[3] = 4;
    drive_src();
    run("cont_done", 600);
    check("cont_count", 32'(order.size()), 32'd8);
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
    check("cont_g0", order_at(0), 32'd0);
    check("cont_g1", order_at(1), 32'd0);
    check("cont_g2", order_at(2), 32'd0);
    check("cont_g3", order_at(3), 32'd0);
`else
    check("cont_g0", order_at(0), 32'd0);
    check("cont_g1", order_at(1), 32'd3);
    check("cont_g2", order_at(2), 32'd0);
    check("cont_g3", order_at(3), 32'd3);
`endif
    check("cont_frames", 32'(frames_sent), 32'd10);
    check("cont_data",   data_err + route_err + ready_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
